control_unit: RTL and testbench
===============================

# control_unit

Main decoder for the RV32I core. Takes opcode, funct3 and funct7 of the instruction in decode and produces every datapath control signal:
- register-file write
- ALU operation and operand selects
- immediate format
- data-memory write and access size
- branch/jump operation
- write-back source

Outputs are registered on the clock so they line up with the pipeline register that feeds execute.

## Interface
Parameters: none.
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0]
- Funct3  in  3  instruction[14:12]
- Funct7  in  7  instruction[31:25]
- RUWr  out  1  register-file write enable
- ALUOp  out  4  ALU operation code
- ImmSrc  out  3  immediate format select
- ALUASrc  out  1  ALU operand A: 0 = rs1, 1 = PC
- ALUBSrc  out  1  ALU operand B: 0 = rs2, 1 = immediate
- DMWr  out  1  data-memory write enable
- DMCtrl  out  3  data-memory access size/sign (funct3 encoding)
- BrOp  out  5  branch operation
- RUDataWrSrc  out  2  write-back source: 00 = ALU, 01 = data memory, 10 = PC+4

## Operation
Encodings:
- ALUOp: {Funct7[5], Funct3} for ALU ops. 0000 = ADD. 1111 = pass operand B.
- ImmSrc: I = 000, S = 001, U = 010, B = 101, J = 110.
- BrOp: 00000 = no branch. {2'b01, Funct3} = conditional branch. 10000 = unconditional jump.

The NOP vector is all outputs zero.

Decode by opcode:
- 0110011 R-type: RUWr=1, ALUOp={Funct7[5],Funct3}, ALUASrc=0, ALUBSrc=0, WB=00.
- 0010011 I-ALU: RUWr=1, ImmSrc=000, ALUBSrc=1, WB=00. ALUOp={Funct7[5],101} when Funct3=101 (SRLI/SRAI); otherwise ALUOp={0,Funct3}.
- 0000011 load: RUWr=1, ImmSrc=000, ALUBSrc=1, ALUOp=0000, DMCtrl=Funct3, WB=01.
- 0100011 store: DMWr=1, RUWr=0, ImmSrc=001, ALUBSrc=1, ALUOp=0000, DMCtrl=Funct3.
- 1100011 branch: RUWr=0, ImmSrc=101, ALUASrc=1, ALUBSrc=1, ALUOp=0000, BrOp={01,Funct3}.
- 1101111 JAL: RUWr=1, ImmSrc=110, ALUASrc=1, ALUBSrc=1, ALUOp=0000, BrOp=10000, WB=10.
- 1100111 JALR: RUWr=1, ImmSrc=000, ALUASrc=0, ALUBSrc=1, ALUOp=0000, BrOp=10000, WB=10.
- 0110111 LUI: RUWr=1, ImmSrc=010, ALUBSrc=1, ALUOp=1111, WB=00.
- 0010111 AUIPC: RUWr=1, ImmSrc=010, ALUASrc=1, ALUBSrc=1, ALUOp=0000, WB=00.

General rules:
- Any other opcode produces the NOP vector.
- Unlisted fields are 0 in every case.
- Funct3/Funct7 values are not checked for legality; only the fields named above are used.
- DMCtrl is 000 for non-memory instructions.

## Timing
- Decode is combinational from the inputs. All outputs are registered on the rising edge of clk: 1-cycle latency from input change to output.
- On rst_n low, all outputs go to the NOP vector immediately, without waiting for a clock edge. They hold there while rst_n is low.
- First decoded value appears on the first rising edge after rst_n deasserts. Reset asserted mid-stream discards the in-flight decode.
- No handshake and no internal state beyond the output register. A new instruction is accepted every cycle.

## Structure
- Package control_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ImmSrc, BrOp and write-back enums
  - ALU_ADD and ALU_PASSB constants
- Sub-module control_decoder is purely combinational: inputs opcode, Funct3, Funct7; outputs the full control vector. The top module adds the async-reset output register.

## Test plan
- Reset: hold rst_n=0 with opcode=0110011 and clock running -> all outputs 0. Release -> R-type decode appears after one edge.
- Store: opcode=0100011, Funct3=000, Funct7=0000000 -> after one edge:
  - DMWr=1, RUWr=0, ImmSrc=001, ALUBSrc=1
  - ALUOp=0000, DMCtrl=000, BrOp=00000
- LUI: opcode=0110111, Funct3=001, Funct7=0000001 -> RUWr=1, ImmSrc=010, ALUBSrc=1, ALUOp=1111, RUDataWrSrc=00, DMWr=0.
- R-type SUB: opcode=0110011, Funct3=000, Funct7=0100000 -> ALUOp=1000, RUWr=1, ALUBSrc=0. I-type SRAI with Funct7=0100000 -> ALUOp=1101, ALUBSrc=1.
- Branch/jump:
  - BNE (1100011, Funct3=001) -> BrOp=01001, ImmSrc=101, RUWr=0.
  - JAL -> BrOp=10000, ImmSrc=110, RUDataWrSrc=10.
  - JALR -> BrOp=10000, ALUASrc=0.
- Load/unknown: LW (0000011, Funct3=010) -> RUDataWrSrc=01, DMCtrl=010. opcode=1111111 -> NOP vector.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, select enums
// and the packed control vector carried from decode into execute.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_U = 3'b010,
    IMM_B = 3'b101,
    IMM_J = 3'b110
  } imm_src_e;

  typedef enum logic [4:0] {
    BR_NONE = 5'b00000,
    BR_COND = 5'b01000,
    BR_JUMP = 5'b10000
  } br_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  typedef struct packed {
    logic       ru_wr;
    logic [3:0] alu_op;
    logic [2:0] imm_src;
    logic       alu_a_src;
    logic       alu_b_src;
    logic       dm_wr;
    logic [2:0] dm_ctrl;
    logic [4:0] br_op;
    logic [1:0] wb_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Conditional branches carry their comparison type in the low three bits.
  function automatic logic [4:0] br_cond_op(input logic [2:0] funct3);
    return BR_COND | {2'b00, funct3};
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode/funct decode into the full control vector.
module control_decoder
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  output ctrl_t      ctrl
);

  // Only Funct7[5] (SUB/SRA select) affects decode.
  logic unused_funct7_s;
  assign unused_funct7_s = ^{Funct7[6], Funct7[4:0]};

  // Per-opcode control decode; anything unrecognised falls back to NOP.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_R: begin
        ctrl.ru_wr  = 1'b1;
        ctrl.alu_op = {Funct7[5], Funct3};
      end
      OP_IMM: begin
        ctrl.ru_wr     = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_b_src = 1'b1;
        if (Funct3 == 3'b101) begin
          ctrl.alu_op = {Funct7[5], 3'b101};
        end else begin
          ctrl.alu_op = {1'b0, Funct3};
        end
      end
      OP_LOAD: begin
        ctrl.ru_wr     = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_b_src = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.dm_ctrl   = Funct3;
        ctrl.wb_src    = WB_MEM;
      end
      OP_STORE: begin
        ctrl.dm_wr     = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.alu_b_src = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.dm_ctrl   = Funct3;
      end
      OP_BRANCH: begin
        ctrl.imm_src   = IMM_B;
        ctrl.alu_a_src = 1'b1;
        ctrl.alu_b_src = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.br_op     = br_cond_op(Funct3);
      end
      OP_JAL: begin
        ctrl.ru_wr     = 1'b1;
        ctrl.imm_src   = IMM_J;
        ctrl.alu_a_src = 1'b1;
        ctrl.alu_b_src = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.br_op     = BR_JUMP;
        ctrl.wb_src    = WB_PC4;
      end
      OP_JALR: begin
        ctrl.ru_wr     = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_b_src = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.br_op     = BR_JUMP;
        ctrl.wb_src    = WB_PC4;
      end
      OP_LUI: begin
        ctrl.ru_wr     = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_b_src = 1'b1;
        ctrl.alu_op    = ALU_PASSB;
      end
      OP_AUIPC: begin
        ctrl.ru_wr     = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_a_src = 1'b1;
        ctrl.alu_b_src = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      default: begin
        ctrl = CTRL_NOP;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder with registered outputs aligned to the decode/execute
// pipeline register; reset forces the NOP vector asynchronously.
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  output logic       RUWr,
  output logic [3:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic       DMWr,
  output logic [2:0] DMCtrl,
  output logic [4:0] BrOp,
  output logic [1:0] RUDataWrSrc
);

  ctrl_t ctrl_s;
  ctrl_t ctrl_r;

  control_decoder u_decoder (
    .opcode (opcode),
    .Funct3 (Funct3),
    .Funct7 (Funct7),
    .ctrl   (ctrl_s)
  );

  // Output register; reset drops any in-flight decode to NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= CTRL_NOP;
    end else begin
      ctrl_r <= ctrl_s;
    end
  end

  assign RUWr        = ctrl_r.ru_wr;
  assign ALUOp       = ctrl_r.alu_op;
  assign ImmSrc      = ctrl_r.imm_src;
  assign ALUASrc     = ctrl_r.alu_a_src;
  assign ALUBSrc     = ctrl_r.alu_b_src;
  assign DMWr        = ctrl_r.dm_wr;
  assign DMCtrl      = ctrl_r.dm_ctrl;
  assign BrOp        = ctrl_r.br_op;
  assign RUDataWrSrc = ctrl_r.wb_src;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus randomized
// back-to-back decode compared against an instruction-level reference model.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       RUWr;
  logic [3:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       ALUASrc;
  logic       ALUBSrc;
  logic       DMWr;
  logic [2:0] DMCtrl;
  logic [4:0] BrOp;
  logic [1:0] RUDataWrSrc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .Funct3      (Funct3),
    .Funct7      (Funct7),
    .RUWr        (RUWr),
    .ALUOp       (ALUOp),
    .ImmSrc      (ImmSrc),
    .ALUASrc     (ALUASrc),
    .ALUBSrc     (ALUBSrc),
    .DMWr        (DMWr),
    .DMCtrl      (DMCtrl),
    .BrOp        (BrOp),
    .RUDataWrSrc (RUDataWrSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector in a fixed field order.
  wire [20:0] got = {RUWr, ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMWr, DMCtrl, BrOp, RUDataWrSrc};

  function automatic logic [20:0] vec(input logic wr, input logic [3:0] alu, input logic [2:0] imm,
                                      input logic a, input logic b, input logic dmw,
                                      input logic [2:0] dmc, input logic [4:0] br, input logic [1:0] wb);
    return {wr, alu, imm, a, b, dmw, dmc, br, wb};
  endfunction

  // Reference: describe each instruction class by what it does, then derive the controls.
  function automatic logic [20:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    string cls;
    logic wr, a, b, dmw;
    logic [3:0] alu;
    logic [2:0] imm, dmc;
    logic [4:0] br;
    logic [1:0] wb;
    case (op)
      7'd51:   cls = "R";
      7'd19:   cls = "IALU";
      7'd3:    cls = "LOAD";
      7'd35:   cls = "STORE";
      7'd99:   cls = "BRANCH";
      7'd111:  cls = "JAL";
      7'd103:  cls = "JALR";
      7'd55:   cls = "LUI";
      7'd23:   cls = "AUIPC";
      default: cls = "NOP";
    endcase
    if (cls == "NOP") return 21'd0;
    wr  = (cls != "STORE") && (cls != "BRANCH");
    dmw = (cls == "STORE");
    a   = (cls == "BRANCH") || (cls == "JAL") || (cls == "AUIPC");
    b   = (cls != "R");
    dmc = (cls == "LOAD" || cls == "STORE") ? f3 : 3'd0;
    br  = (cls == "BRANCH") ? 5'(8 + f3) : ((cls == "JAL" || cls == "JALR") ? 5'd16 : 5'd0);
    wb  = (cls == "LOAD") ? 2'd1 : ((cls == "JAL" || cls == "JALR") ? 2'd2 : 2'd0);
    if (cls == "STORE") imm = 3'd1;
    else if (cls == "LUI" || cls == "AUIPC") imm = 3'd2;
    else if (cls == "BRANCH") imm = 3'd5;
    else if (cls == "JAL") imm = 3'd6;
    else imm = 3'd0;
    if (cls == "R") alu = 4'(f3 + (f7[5] ? 8 : 0));
    else if (cls == "IALU") alu = 4'(f3 + ((f3 == 3'd5 && f7[5]) ? 8 : 0));
    else if (cls == "LUI") alu = 4'd15;
    else alu = 4'd0;
    return {wr, alu, imm, a, b, dmw, dmc, br, wb};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    opcode = op;
    Funct3 = f3;
    Funct7 = f7;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    rst_n  = 1'b0;
    opcode = 7'b0110011;
    Funct3 = 3'b000;
    Funct7 = 7'b0000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (got !== 21'd0) $display("FAIL reset_hold cycle %0d: got %h expected %h", i, got, 21'd0);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    exp = vec(1'b1, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 5'b00000, 2'b00);
    total_cnt++;
    if (got !== exp) $display("FAIL reset_release: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_store();
    logic [20:0] exp;
    drive(7'b0100011, 3'b000, 7'b0000000);
    exp = vec(1'b0, 4'b0000, 3'b001, 1'b0, 1'b1, 1'b1, 3'b000, 5'b00000, 2'b00);
    total_cnt++;
    if (got !== exp) $display("FAIL store_sb: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_lui();
    logic [20:0] exp;
    drive(7'b0110111, 3'b001, 7'b0000001);
    exp = vec(1'b1, 4'b1111, 3'b010, 1'b0, 1'b1, 1'b0, 3'b000, 5'b00000, 2'b00);
    total_cnt++;
    if (got !== exp) $display("FAIL lui: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_alu_funct7();
    logic [20:0] exp;
    drive(7'b0110011, 3'b000, 7'b0100000);
    exp = vec(1'b1, 4'b1000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 5'b00000, 2'b00);
    total_cnt++;
    if (got !== exp) $display("FAIL r_sub: got %h expected %h", got, exp);
    else pass_cnt++;
    drive(7'b0010011, 3'b101, 7'b0100000);
    exp = vec(1'b1, 4'b1101, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 5'b00000, 2'b00);
    total_cnt++;
    if (got !== exp) $display("FAIL i_srai: got %h expected %h", got, exp);
    else pass_cnt++;
    drive(7'b0010011, 3'b000, 7'b0100000);
    exp = vec(1'b1, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 5'b00000, 2'b00);
    total_cnt++;
    if (got !== exp) $display("FAIL i_addi_f7_ignored: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_branch_jump();
    logic [20:0] exp;
    drive(7'b1100011, 3'b001, 7'b0000000);
    exp = vec(1'b0, 4'b0000, 3'b101, 1'b1, 1'b1, 1'b0, 3'b000, 5'b01001, 2'b00);
    total_cnt++;
    if (got !== exp) $display("FAIL bne: got %h expected %h", got, exp);
    else pass_cnt++;
    drive(7'b1101111, 3'b011, 7'b1111111);
    exp = vec(1'b1, 4'b0000, 3'b110, 1'b1, 1'b1, 1'b0, 3'b000, 5'b10000, 2'b10);
    total_cnt++;
    if (got !== exp) $display("FAIL jal: got %h expected %h", got, exp);
    else pass_cnt++;
    drive(7'b1100111, 3'b000, 7'b0000000);
    exp = vec(1'b1, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 5'b10000, 2'b10);
    total_cnt++;
    if (got !== exp) $display("FAIL jalr: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_load_unknown();
    logic [20:0] exp;
    drive(7'b0000011, 3'b010, 7'b0000000);
    exp = vec(1'b1, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b010, 5'b00000, 2'b01);
    total_cnt++;
    if (got !== exp) $display("FAIL lw: got %h expected %h", got, exp);
    else pass_cnt++;
    drive(7'b1111111, 3'b111, 7'b1111111);
    total_cnt++;
    if (got !== 21'd0) $display("FAIL unknown_opcode: got %h expected %h", got, 21'd0);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [20:0] exp;
    drive(7'b0010111, 3'b000, 7'b0000000);
    exp = vec(1'b1, 4'b0000, 3'b010, 1'b1, 1'b1, 1'b0, 3'b000, 5'b00000, 2'b00);
    total_cnt++;
    if (got !== exp) $display("FAIL auipc_before_reset: got %h expected %h", got, exp);
    else pass_cnt++;
    opcode = 7'b1101111;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (got !== 21'd0) $display("FAIL async_reset_immediate: got %h expected %h", got, 21'd0);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (got !== 21'd0) $display("FAIL reset_discards_inflight: got %h expected %h", got, 21'd0);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    exp = model(7'b1101111, 3'b000, 7'b0000000);
    total_cnt++;
    if (got !== exp) $display("FAIL decode_after_midreset: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [20:0] exp_q [$];
    logic [20:0] exp;
    logic [6:0]  op;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 8)];
      opcode = op;
      Funct3 = 3'($urandom);
      Funct7 = 7'($urandom);
      exp_q.push_back(model(opcode, Funct3, Funct7));
      @(negedge clk);
      exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL random_%0d op=%b f3=%b f7=%b: got %h expected %h",
                                i, opcode, Funct3, Funct7, got, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_lui();
    test_alu_funct7();
    test_branch_jump();
    test_load_unknown();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
